bridge_fc_tracker: RTL



---
 rtl/bridge_pkg.sv | 37 +++
 rtl/bridge_fc_credit.sv | 67 ++++++
 rtl/bridge_fc_tracker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge flow-credit tracker.
//   - fc_sel encoding presented to the PCIe core
//   - Tx consumption class encoding (P / NP / CPL / ignored)
//   - tracker state encoding
//   - fc_data_credits(): payload length in DW -> data credits (ceil(len/4)),
//     with a length of 0 meaning 1024 DW (256 credits)
package bridge_pkg;

    // Core fc_sel: transmit-available credits.
    localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;

    localparam int NUM_CLASSES = 3;

    typedef enum logic [1:0] {
        FC_P    = 2'd0,
        FC_NP   = 2'd1,
        FC_CPL  = 2'd2,
        FC_NONE = 2'd3
    } fc_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_RUN  = 2'd3
    } fc_state_e;

    // One data credit covers 4 DW; the largest result is 256.
    function automatic logic [8:0] fc_data_credits(input logic [9:0] len_dw);
        logic [10:0] len_ext;
        logic [10:0] rounded;
        len_ext = (len_dw == 10'd0) ? 11'd1024 : {1'b0, len_dw};
        rounded = (len_ext + 11'd3) >> 2;
        return rounded[8:0];
    endfunction

endpackage

// File: rtl/bridge_fc_credit.sv
// One credit class (header + data) shadow counter.
//   clk_i, srst_i   : clock, synchronous active-high reset
//   clear_i         : force both shadows and flags to zero (highest priority)
//   load_i          : take core_hdr_i/core_data_i as the base instead of the shadow
//   cons_hdr_i      : subtract one header credit this cycle
//   cons_data_i     : data credits to subtract this cycle
//   core_hdr_i/core_data_i : core-reported available credits
//   hdr_ok_o        : registered, header shadow != 0
//   data_ok_o       : registered, data shadow >= DATA_THR
// The subtraction is always applied on top of the chosen base, so a TLP
// launched during the load cycle is not lost. Both shadows clamp at zero.
module bridge_fc_credit #(
    parameter int HDR_W    = 8,
    parameter int DATA_W   = 12,
    parameter int DATA_THR = 32
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              cons_hdr_i,
    input  logic [8:0]        cons_data_i,
    input  logic [HDR_W-1:0]  core_hdr_i,
    input  logic [DATA_W-1:0] core_data_i,
    output logic              hdr_ok_o,
    output logic              data_ok_o
);

    logic [HDR_W-1:0]  hdr_q, hdr_d, hdr_base;
    logic [DATA_W-1:0] data_q, data_d, data_base;
    logic [HDR_W:0]    hdr_diff;
    logic [DATA_W:0]   data_diff;
    logic              hdr_ok_q, data_ok_q;

    always_comb begin
        hdr_base  = load_i ? core_hdr_i  : hdr_q;
        data_base = load_i ? core_data_i : data_q;
        // One extra bit: a set MSB means the result went negative.
        hdr_diff  = {1'b0, hdr_base}  - (HDR_W+1)'(cons_hdr_i);
        data_diff = {1'b0, data_base} - (DATA_W+1)'(cons_data_i);
        hdr_d     = hdr_diff[HDR_W]   ? '0 : hdr_diff[HDR_W-1:0];
        data_d    = data_diff[DATA_W] ? '0 : data_diff[DATA_W-1:0];
        if (clear_i) begin
            hdr_d  = '0;
            data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            hdr_q     <= '0;
            data_q    <= '0;
            hdr_ok_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            // Flags follow the next shadow value so they change together.
            hdr_ok_q  <= (hdr_d != '0);
            data_ok_q <= (data_d >= DATA_W'(DATA_THR));
        end
    end

    assign hdr_ok_o  = hdr_ok_q;
    assign data_ok_o = data_ok_q;

endmodule

// File: rtl/bridge_fc_tracker.sv
// Flow-credit tracker for the PCIe bridge.
// Samples the core's Tx-available credits after link-up, keeps per-class
// shadow counters decremented by each launched TLP, and resynchronises with
// the core every REFRESH cycles. Drives ok-to-transmit flags and the bridge
// module enables from a sequenced state machine.
// Ports:
//   Ctrl_CLK, Ctrl_RST       : clock, synchronous active-high reset
//   Ctrl_Link_Up             : core link-up; low returns to IDLE next cycle
//   Ctrl_fc_ph/nph/cplh      : core header credits
//   Ctrl_fc_pd/npd/cpld      : core data credits
//   Ctrl_Tx_Cons_*           : per-TLP consumption from the Tx bridge
//   Ctrl_fc_sel              : constant Tx-available select to the core
//   Ctrl_Tx_FC               : {cpld,cplh,npd,nph,pd,ph} ok flags
//   Ctrl_Tx_Ready/Rx_Ready/OCP_Ready : bridge module enables
module bridge_fc_tracker
    import bridge_pkg::*;
#(
    parameter int HDR_W          = 8,
    parameter int DATA_W         = 12,
    parameter int MAX_PAYLOAD_DW = 128,
    parameter int SEL_LAT        = 4,
    parameter int REFRESH        = 64
) (
    input  logic              Ctrl_CLK,
    input  logic              Ctrl_RST,
    input  logic              Ctrl_Link_Up,
    input  logic [HDR_W-1:0]  Ctrl_fc_ph,
    input  logic [HDR_W-1:0]  Ctrl_fc_nph,
    input  logic [HDR_W-1:0]  Ctrl_fc_cplh,
    input  logic [DATA_W-1:0] Ctrl_fc_pd,
    input  logic [DATA_W-1:0] Ctrl_fc_npd,
    input  logic [DATA_W-1:0] Ctrl_fc_cpld,
    input  logic              Ctrl_Tx_Cons_Valid,
    input  logic [1:0]        Ctrl_Tx_Cons_Type,
    input  logic              Ctrl_Tx_Cons_Data,
    input  logic [9:0]        Ctrl_Tx_Cons_Len,
    output logic [2:0]        Ctrl_fc_sel,
    output logic [5:0]        Ctrl_Tx_FC,
    output logic              Ctrl_Tx_Ready,
    output logic              Ctrl_Rx_Ready,
    output logic              Ctrl_OCP_Ready
);

    localparam int DATA_THR = MAX_PAYLOAD_DW / 4;
    localparam int CNT_MAX  = (REFRESH > SEL_LAT) ? REFRESH : SEL_LAT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    fc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_ready_q, rx_ready_d;

    logic             clear_shadow;
    logic             load_shadow;
    logic [8:0]       cons_credits;
    logic [5:0]       fc_ok;

    logic [HDR_W-1:0]  core_hdr  [NUM_CLASSES];
    logic [DATA_W-1:0] core_data [NUM_CLASSES];

    assign core_hdr[0]  = Ctrl_fc_ph;
    assign core_hdr[1]  = Ctrl_fc_nph;
    assign core_hdr[2]  = Ctrl_fc_cplh;
    assign core_data[0] = Ctrl_fc_pd;
    assign core_data[1] = Ctrl_fc_npd;
    assign core_data[2] = Ctrl_fc_cpld;

    assign cons_credits = fc_data_credits(Ctrl_Tx_Cons_Len);

    // Sequencing: WAIT covers the core's select-to-valid latency; one cycle
    // of SEL_LAT counting per WAIT cycle, then a single LOAD cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (Ctrl_Link_Up) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(SEL_LAT - 1)) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(REFRESH - 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!Ctrl_Link_Up) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Tx stays enabled across refresh WAITs once the first load happened.
    always_comb begin
        rx_ready_d   = (state_d != ST_IDLE);
        tx_ready_d   = (state_d != ST_IDLE) && (tx_ready_q || (state_q == ST_LOAD));
        clear_shadow = (state_d == ST_IDLE);
        load_shadow  = (state_q == ST_LOAD);
    end

    always_ff @(posedge Ctrl_CLK) begin
        if (Ctrl_RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_ready_q <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_ready_q <= tx_ready_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
            logic       cons_hit;
            logic [8:0] cons_data;

            assign cons_hit  = Ctrl_Tx_Cons_Valid && (Ctrl_Tx_Cons_Type == 2'(gi));
            assign cons_data = (cons_hit && Ctrl_Tx_Cons_Data) ? cons_credits : 9'd0;

            bridge_fc_credit #(
                .HDR_W    (HDR_W),
                .DATA_W   (DATA_W),
                .DATA_THR (DATA_THR)
            ) u_credit (
                .clk_i       (Ctrl_CLK),
                .srst_i      (Ctrl_RST),
                .clear_i     (clear_shadow),
                .load_i      (load_shadow),
                .cons_hdr_i  (cons_hit),
                .cons_data_i (cons_data),
                .core_hdr_i  (core_hdr[gi]),
                .core_data_i (core_data[gi]),
                .hdr_ok_o    (fc_ok[2*gi]),
                .data_ok_o   (fc_ok[2*gi+1])
            );
        end
    endgenerate

    assign Ctrl_fc_sel    = FC_SEL_TX_AVAIL;
    assign Ctrl_Tx_FC     = fc_ok;
    assign Ctrl_Tx_Ready  = tx_ready_q;
    assign Ctrl_Rx_Ready  = rx_ready_q;
    assign Ctrl_OCP_Ready = rx_ready_q;

endmodule
